ripple_count_sampler: RTL and testbench

- Downstream consumer of the 4-bit asynchronous ripple down counter.
- Ripple outputs settle bit by bit, so intermediate codes are visible while the count changes. This block moves the count into the system clock domain.
- It synchronizes and stability-filters the raw count, presents a clean registered value, flags decrements, wraps and illegal jumps, and keeps a saturating wrap tally for downstream logic.

---
 rtl/ripple_count_sampler.sv | 158 +++++++++++++++
 tb/tb_ripple_count_sampler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Brings the value of a 4-bit asynchronous ripple down counter into the clk
//   domain. Each bit passes through a synchronizer. A stability filter then
//   rejects the partial codes that appear while the ripple settles. Every
//   accepted value is classified as a single decrement, a wrap (0 -> all-ones)
//   or an illegal jump. A saturating tally counts the wraps.
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   rst         asynchronous active-low reset; release synchronous to clk
//   cnt_in      raw ripple-counter value, asynchronous to clk
//   cnt_out     last accepted stable count (registered)
//   cnt_valid   high once the first stable value has been accepted
//   step_pulse  one-cycle pulse: accepted value is the previous value minus 1
//   wrap_pulse  one-cycle pulse: accepted transition is from 0 to all-ones
//   err_pulse   one-cycle pulse: accepted value is not the previous value minus 1
//   wrap_count  saturating number of wraps since reset
module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,  // legal range 2..4
  parameter int STABLE_CYCLES = 2,  // legal range 1..7
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_valid,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int            MATCH_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [MATCH_W-1:0] STABLE_M = MATCH_W'(STABLE_CYCLES);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-bit synchronizer. Index 0 samples cnt_in, and the top index is the
  // synchronized bus s. The chain resets to all-ones because that is the
  // counter's own reset value. The first sample after reset is then
  // indistinguishable from a settled count.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  // NOTE: every flop in a clocked block uses non-blocking assignment. All of
  // them then sample their inputs before any of them change. This is what
  // makes the chain shift one stage per edge instead of collapsing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], cnt_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stability filter. A new code restarts the run length at 1. The value is
  // accepted once it has been seen STABLE_CYCLES times in a row.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   cand;
  logic [MATCH_W-1:0] match;
  logic               stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand  <= '1;
      match <= '0;
    end else if (s != cand) begin
      cand  <= s;
      match <= MATCH_W'(1);
    end else if (match < STABLE_M) begin
      match <= match + MATCH_W'(1);
    end
  end

  assign stable = (s == cand) && (match >= STABLE_M);

  // ---------------------------------------------------------------------------
  // Acceptance FSM. The next-state / next-output logic is computed here. The
  // outputs are then registered below, so every pulse lines up with the cnt_out
  // update that caused it.
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_d;
  logic               valid_d, step_d, wrap_d, err_d;
  logic [WRAP_W-1:0]  wrapc_d;
  logic [WIDTH-1:0]   cnt_dec;

  assign cnt_dec = cnt_out - WIDTH'(1);

  // NOTE: every signal written here gets a default before the case. A path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_out;
    valid_d = cnt_valid;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    wrapc_d = wrap_count;

    case (state_q)
      INIT: begin
        // First acceptance only establishes the reference, so it raises no pulse.
        if (stable) begin
          cnt_d   = cand;
          valid_d = 1'b1;
          state_d = TRACK;
        end
      end

      TRACK: begin
        if (stable && (cand != cnt_out)) begin
          cnt_d = cand;
          if (cand == cnt_dec) begin
            step_d = 1'b1;
            // A decrement out of 0 can only land on all-ones, so this is a wrap.
            if (cnt_out == '0) begin
              wrap_d = 1'b1;
              if (wrap_count != '1) wrapc_d = wrap_count + WRAP_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      cnt_out    <= '1;
      cnt_valid  <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_out    <= cnt_d;
      cnt_valid  <= valid_d;
      step_pulse <= step_d;
      wrap_pulse <= wrap_d;
      err_pulse  <= err_d;
      wrap_count <= wrapc_d;
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler
//   Directed bench for ripple_count_sampler with the default parameters
//   (WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=2, WRAP_W=8). Inputs change on the
//   falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_ripple_count_sampler;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic [3:0] cnt_out;
  logic       cnt_valid;
  logic       step_pulse;
  logic       wrap_pulse;
  logic       err_pulse;
  logic [7:0] wrap_count;

  int total = 0;
  int bad   = 0;

  // Pulse tallies gathered by hold(), cleared by clear_tally().
  int n_step, n_wrap, n_err;
  bit seen9;

  ripple_count_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_out    (cnt_out),
    .cnt_valid  (cnt_valid),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    n_step = 0;
    n_wrap = 0;
    n_err  = 0;
    seen9  = 1'b0;
  endtask

  // Present value v from the next falling edge and observe n rising edges.
  task automatic hold(input logic [3:0] v, input int n);
    @(negedge clk);
    cnt_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
      n_step += int'(step_pulse);
      n_wrap += int'(wrap_pulse);
      n_err  += int'(err_pulse);
      if (cnt_out == 4'h9) seen9 = 1'b1;
    end
  endtask

  initial begin
    int first_k;
    int step_k;
    bit got_valid;

    rst    = 1'b0;
    cnt_in = 4'hF;
    #12;

    // ---- reset state ----
    check("rst_cnt_out",    32'(cnt_out),    32'hF);
    check("rst_cnt_valid",  32'(cnt_valid),  32'h0);
    check("rst_pulses",     32'({step_pulse, wrap_pulse, err_pulse}), 32'h0);
    check("rst_wrap_count", 32'(wrap_count), 32'h0);

    // ---- release, acquire F within 5 edges ----
    @(negedge clk);
    rst = 1'b1;
    got_valid = 1'b0;
    clear_tally();
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (cnt_valid) got_valid = 1'b1;
    end
    check("acq_valid_by_5", 32'(got_valid), 32'h1);
    hold(4'hF, 10);
    check("acq_cnt_out", 32'(cnt_out), 32'hF);
    check("acq_no_pulses", 32'(n_step + n_wrap + n_err), 32'h0);

    // ---- F -> E, exact latency of 5 edges ----
    @(negedge clk);
    cnt_in  = 4'hE;
    first_k = 0;
    step_k  = 0;
    clear_tally();
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (first_k == 0 && cnt_out != 4'hF) first_k = k;
      if (step_pulse && step_k == 0) step_k = k;
      n_step += int'(step_pulse);
      n_wrap += int'(wrap_pulse);
      n_err  += int'(err_pulse);
    end
    check("lat_edges",      32'(first_k), 32'd5);
    check("lat_cnt_out",    32'(cnt_out), 32'hE);
    check("lat_step_edge",  32'(step_k),  32'd5);
    check("lat_step_once",  32'(n_step),  32'd1);
    check("lat_no_wrap_err", 32'(n_wrap + n_err), 32'h0);

    // ---- clean count down D..0, then wrap 0 -> F ----
    clear_tally();
    for (int v = 13; v >= 0; v--) hold(4'(v), 7);
    check("down_cnt_out", 32'(cnt_out), 32'h0);
    check("down_steps",   32'(n_step),  32'd14);
    check("down_no_err",  32'(n_err + n_wrap), 32'h0);
    clear_tally();
    hold(4'hF, 7);
    check("wrap_cnt_out", 32'(cnt_out),    32'hF);
    check("wrap_step",    32'(n_step),     32'd1);
    check("wrap_pulse",   32'(n_wrap),     32'd1);
    check("wrap_no_err",  32'(n_err),      32'd0);
    check("wrap_count_1", 32'(wrap_count), 32'd1);

    // ---- accept 8 (a jump), then 1-cycle glitch 9 settling to 7 ----
    clear_tally();
    hold(4'h8, 7);
    check("jump8_cnt_out", 32'(cnt_out), 32'h8);
    check("jump8_err",     32'(n_err),   32'd1);
    clear_tally();
    hold(4'h9, 1);
    hold(4'h7, 10);
    check("glitch_never9",  32'(seen9),   32'h0);
    check("glitch_cnt_out", 32'(cnt_out), 32'h7);
    check("glitch_step",    32'(n_step),  32'd1);
    check("glitch_no_err",  32'(n_err),   32'd0);

    // ---- accept 5, then jump to 2 ----
    hold(4'h5, 7);
    clear_tally();
    hold(4'h2, 10);
    check("jump2_cnt_out", 32'(cnt_out),   32'h2);
    check("jump2_err",     32'(n_err),     32'd1);
    check("jump2_no_step", 32'(n_step),    32'd0);
    check("jump2_valid",   32'(cnt_valid), 32'h1);

    // ---- 300 wraps; tally starts at 1, so saturation comes after 254 more ----
    clear_tally();
    for (int w = 1; w <= 300; w++) begin
      hold(4'h0, 7);
      hold(4'hF, 7);
      if (w == 253) check("sat_254", 32'(wrap_count), 32'd254);
      if (w == 254) check("sat_255", 32'(wrap_count), 32'd255);
    end
    check("sat_hold",        32'(wrap_count), 32'd255);
    check("sat_wrap_pulses", 32'(n_wrap),     32'd300);

    // ---- reset mid-acquisition, off the clock edge ----
    @(negedge clk);
    cnt_in = 4'h7;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_cnt_out",    32'(cnt_out),    32'hF);
    check("mid_rst_valid",      32'(cnt_valid),  32'h0);
    check("mid_rst_wrap_count", 32'(wrap_count), 32'h0);
    check("mid_rst_pulses",     32'({step_pulse, wrap_pulse, err_pulse}), 32'h0);

    // ---- re-acquire after release, first acceptance raises nothing ----
    @(negedge clk);
    rst = 1'b1;
    clear_tally();
    hold(4'h7, 10);
    check("reacq_cnt_out",   32'(cnt_out),   32'h7);
    check("reacq_valid",     32'(cnt_valid), 32'h1);
    check("reacq_no_pulses", 32'(n_step + n_wrap + n_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
